// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD     = 2'd0,
    SEL_INCR     = 2'd1,
    SEL_REDIRECT = 2'd2
  } pc_sel_t;

  localparam int unsigned PC_INCR              = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_controller_if.sv
// Fetch-side bus: instruction-memory request/ack plus the decode handshake.
interface pc_fetch_controller_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: hold, sequential increment, or redirect target.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_t           sel,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_next
);

  // Increment wraps naturally at the address width; targets are word-aligned.
  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_INCR:     pc_next = pc + ADDR_W'(PC_INCR);
      SEL_REDIRECT: pc_next = redirect_pc & ~ADDR_W'(2'b11);
      default:      pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// Fetch controller: IDLE/FETCH/HOLD/HALT sequencing with redirect and halt.
// Optional misaligned-redirect fault detection is enabled by PC_ALIGN_CHECK_EN.
module pc_fetch_controller
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic [ADDR_W-1:0]     pc,
  output logic                  fault,
  pc_fetch_controller_if.master bus
);

  state_t            state_reg;
  logic              imem_req_reg;
  logic              instr_valid_reg;
  logic              halt_pend_reg;
  logic              fault_reg;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  pc_sel_t           pc_sel;
  logic              misalign;
  logic              redirect_live;

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign redirect_live = redirect_valid && ((state_reg == FETCH) || (state_reg == HOLD));

  // A bad redirect leaves the PC alone; a good one beats any same-cycle ack.
  always_comb begin
    pc_sel = SEL_HOLD;
    if (redirect_valid) begin
      pc_sel = misalign ? SEL_HOLD : SEL_REDIRECT;
    end else if ((state_reg == FETCH) && bus.imem_ack) begin
      pc_sel = SEL_INCR;
    end
  end

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_sel (
    .pc          (pc_reg),
    .sel         (pc_sel),
    .redirect_pc (redirect_pc),
    .pc_next     (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      halt_pend_reg   <= 1'b0;
      fault_reg       <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
    end else if (misalign) begin
      fault_reg       <= 1'b1;
      state_reg       <= HALT;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      halt_pend_reg   <= 1'b0;
    end else if (redirect_live) begin
      instr_valid_reg <= 1'b0;
      halt_pend_reg   <= 1'b0;
      if (halt) begin
        state_reg    <= HALT;
        imem_req_reg <= 1'b0;
      end else begin
        state_reg    <= FETCH;
        imem_req_reg <= 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (halt) begin
            state_reg <= HALT;
          end else if (start) begin
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end
        end
        FETCH: begin
          // A halt seen while waiting is remembered until the word is handed off.
          halt_pend_reg <= halt_pend_reg | halt;
          if (bus.imem_ack) begin
            instr_reg       <= bus.imem_rdata;
            instr_pc_reg    <= pc_reg;
            state_reg       <= HOLD;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_reg <= 1'b0;
            halt_pend_reg   <= 1'b0;
            if (halt || halt_pend_reg) begin
              state_reg <= HALT;
            end else begin
              state_reg    <= FETCH;
              imem_req_reg <= 1'b1;
            end
          end else begin
            halt_pend_reg <= halt_pend_reg | halt;
          end
        end
        HALT: begin
          if (start) begin
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign pc              = pc_reg;
  assign fault           = fault_reg;

endmodule
